mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter BURST_MAX, default 8, meaning the maximum number of consecutive locked accesses per grant while other requesters wait.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  3  access request, one bit per requester: bit0 CPU controller, bit1 display DMA, bit2 program loader.
REQ-005 lock  input  3  per-requester request to hold ownership for the next access.
REQ-006 req_addr  input  48  three 16-bit addresses; requester n uses bits [16n+15:16n].
REQ-007 req_wdata  input  48  three 16-bit write data words, packed the same way as req_addr.
REQ-008 req_we  input  3  per-requester write enable: 1 = write, 0 = read.
REQ-009 gnt  output  3  one-hot-or-zero ownership indication.
REQ-010 ack  output  3  one-cycle completion pulse for the owner.
REQ-011 rdata  output  16  read data, valid while ack is high for a read.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write strobe.
REQ-014 mem_addr  output  16  memory address.
REQ-015 mem_wdata  output  16  memory write data.
REQ-016 mem_rdata  input  16  memory read data, valid one cycle after a read strobe.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP; all outputs SHALL be registered.
REQ-019 IDLE: if req is nonzero, the FSM SHALL select a winner W, set gnt to one-hot W and move to ACCESS on the next edge; otherwise it SHALL stay in IDLE with gnt=0.
REQ-020 ACCESS: the block SHALL drive mem_en=1 and copy mem_we, mem_addr and mem_wdata from W's request for exactly one cycle, then move to RESP.
REQ-021 RESP: the block SHALL hold mem_en=0, pulse ack[W] for one cycle and set rdata to mem_rdata for reads; for writes rdata SHALL hold its previous value.
REQ-022 Read latency from the req rising edge to ack SHALL be 3 cycles when the block is idle.
REQ-023 RESP exit, priority 1: if lock[W] and req[W] are both high and the burst count is below BURST_MAX (or no other req bit is set), the FSM SHALL return to ACCESS with the same W, without re-arbitration.
REQ-024 RESP exit, priority 2: otherwise, if any req bit is set, the FSM SHALL arbitrate in the same cycle and go to ACCESS with the new W and gnt updated.
REQ-025 RESP exit, priority 3: otherwise the FSM SHALL go to IDLE with gnt=0.
REQ-026 The 4-bit burst counter SHALL clear on every new grant and increment on each locked re-entry to ACCESS; it SHALL saturate and SHALL NOT wrap.
REQ-027 Once ACCESS is entered, the access SHALL complete and ack SHALL pulse even if req[W] drops.
REQ-028 Requesters SHALL hold address, data and we stable from req assertion until ack; the arbiter SHALL sample them only in the ACCESS cycle.
REQ-029 Request bits for non-owners SHALL be ignored until arbitration; at most one gnt bit and one ack bit SHALL ever be high.

Reset
REQ-030 While rst is high, outputs SHALL take these values immediately, asynchronously: gnt=0, ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0; the FSM SHALL be in IDLE, the burst counter 0 and the round-robin pointer 0.
REQ-031 Reset asserted mid-access SHALL abort the access with no ack; arbitration SHALL restart on the first edge after rst falls.

Configuration
REQ-032 With ROUND_ROBIN_EN defined, the winner SHALL be the first set req bit searched upward, with wrap, starting from (last winner + 1) mod 3; the pointer SHALL update on each new grant.
REQ-033 Without ROUND_ROBIN_EN, the block SHALL use fixed priority bit0 > bit1 > bit2 and SHALL contain no pointer register.

Verification
REQ-034 Single read: req=001, addr0=0x0010, we=0, mem_rdata=0xBEEF -> mem_en pulses 1 cycle with mem_addr=0x0010; 3 cycles after req rises, ack=001 and rdata=0xBEEF.
REQ-035 Single write: req=010, addr1=0x0200, wdata1=0x1234, we=1 -> mem_we=1, mem_wdata=0x1234 for one cycle; ack=010; rdata unchanged.
REQ-036 Contention: req=111 held, lock=0, with ROUND_ROBIN_EN -> grant order 0,1,2,0; without it -> grant order 0,0,0.
REQ-037 Burst limit: req=011, lock=001 held, BURST_MAX=8 -> requester 0 gets 9 back-to-back accesses, then gnt=010.
REQ-038 Reset mid-access: rst asserted during ACCESS -> mem_en and gnt drop immediately; no ack; after release, the pending req is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester memory arbiter with locked bursts (optional ROUND_ROBIN_EN)
module mem_arbiter #(
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  lock,
    input  logic [47:0] req_addr,
    input  logic [47:0] req_wdata,
    input  logic [2:0]  req_we,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [1:0]  owner;
    logic [3:0]  burst;
    logic        cur_we;
    logic [1:0]  win;
    logic [1:0]  sel;
    logic [2:0]  others;
    logic        relock;
    logic        start;
    logic        new_grant;

`ifdef ROUND_ROBIN_EN
    logic [1:0]  ptr;
    logic [2:0]  idx;
    logic        found;

    // ptr holds the search start: one past the last winner
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && req[idx]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win = 2'd2;
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
    end
`endif

    always_comb begin
        others    = req & ~(3'b001 << owner);
        relock    = (state == RESP) && lock[owner] && req[owner] &&
                    ((32'(burst) < BURST_MAX) || (others == 3'b000));
        sel       = relock ? owner : win;
        start     = ((state == IDLE) || (state == RESP)) && (relock || (|req));
        new_grant = start && !relock;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            burst     <= 4'd0;
            cur_we    <= 1'b0;
            gnt       <= 3'b000;
            ack       <= 3'b000;
            rdata     <= 16'h0000;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            busy      <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr       <= 2'd0;
`endif
        end else begin
            ack <= 3'b000;
            case (state)
                IDLE: begin
                    gnt  <= 3'b000;
                    busy <= 1'b0;
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    // memory data arrives during RESP, so capture it on the way out
                    ack <= 3'b001 << owner;
                    if (!cur_we) rdata <= mem_rdata;
                    state <= IDLE;
                    gnt   <= 3'b000;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (start) begin
                state     <= ACCESS;
                owner     <= sel;
                gnt       <= 3'b001 << sel;
                busy      <= 1'b1;
                mem_en    <= 1'b1;
                mem_we    <= req_we[sel];
                cur_we    <= req_we[sel];
                mem_addr  <= req_addr[{sel, 4'h0} +: 16];
                mem_wdata <= req_wdata[{sel, 4'h0} +: 16];
                if (new_grant) begin
                    burst <= 4'd0;
`ifdef ROUND_ROBIN_EN
                    ptr   <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
`endif
                end else if (burst != 4'hF) begin
                    burst <= burst + 4'd1;
                end
            end
        end
    end

endmodule
